i2s_rx_capture: RTL and testbench

Receives the ADAU1761 ADC serial stream (I2S, 32-bit slots) on the `clk_100` domain and delivers parallel left/right samples with a one-cycle valid strobe. It is the receive direction of the I2S link whose transmit side carries `hphone_l` to the codec, and it feeds line-in audio to the music player and the wave display. All I2S pins are oversampled as data; there is no second clock domain.

---
 rtl/i2s_rx_capture_pkg.sv | 21 ++
 rtl/i2s_rx_capture_if.sv | 25 ++
 rtl/i2s_rx_capture_sync_edge.sv | 48 ++++
 rtl/i2s_rx_capture.sv | 187 ++++++++++++++++++
 tb/tb_i2s_rx_capture.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_rx_capture_pkg.sv
// Shared I2S definitions: FSM encodings, slot geometry and channel codes.
// Used by both the receive capture and the transmit side of the link.
package i2s_pkg;

  localparam int I2S_SLOT_BITS = 32;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  typedef logic [1:0] i2s_state_t;

  localparam i2s_state_t ST_IDLE  = 2'd0;
  localparam i2s_state_t ST_ARM   = 2'd1;
  localparam i2s_state_t ST_SHIFT = 2'd2;
  localparam i2s_state_t ST_WAIT  = 2'd3;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/i2s_rx_capture_if.sv
// I2S receive bundle: codec pins and clear in, captured stereo samples and error status out.
// master = stimulus/consumer side, slave = the capture block.
interface i2s_rx_capture_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic                    i2s_bclk;
  logic                    i2s_lr;
  logic                    i2s_sdata;
  logic                    clear_error;
  logic [SAMPLE_WIDTH-1:0] left_sample;
  logic [SAMPLE_WIDTH-1:0] right_sample;
  logic                    sample_valid;
  logic                    frame_error;
  logic [7:0]              err_count;

  modport master (
    output i2s_bclk, i2s_lr, i2s_sdata, clear_error,
    input  left_sample, right_sample, sample_valid, frame_error, err_count
  );

  modport slave (
    input  i2s_bclk, i2s_lr, i2s_sdata, clear_error,
    output left_sample, right_sample, sample_valid, frame_error, err_count
  );
endinterface

// File: rtl/i2s_rx_capture_sync_edge.sv
// Synchronizes bclk/lr/sdata into clk and emits a registered one-cycle tick per bclk rise.
// lr/sdata outputs are registered alongside the tick so they line up with it.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk_i,
  input  logic lr_i,
  input  logic sdata_i,
  output logic lr_o,
  output logic sdata_o,
  output logic bit_tick_o
);

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lr_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic                   bclk_prev_q;
  logic                   tick_q;
  logic                   lr_q;
  logic                   sdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q  <= '0;
      lr_sync_q    <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
      tick_q       <= 1'b0;
      lr_q         <= 1'b0;
      sdata_q      <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk_i};
      lr_sync_q    <= {lr_sync_q[SYNC_STAGES-2:0], lr_i};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_i};
      bclk_prev_q  <= bclk_sync_q[SYNC_STAGES-1];
      tick_q       <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
      lr_q         <= lr_sync_q[SYNC_STAGES-1];
      sdata_q      <= sdata_sync_q[SYNC_STAGES-1];
    end
  end

  assign lr_o       = lr_q;
  assign sdata_o    = sdata_q;
  assign bit_tick_o = tick_q;

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S (32-bit slot) ADC receiver: oversampled pins, left+right paired into one valid pulse per frame.
// Optional saturating truncation counter built when I2S_RX_ERR_CNT_EN is defined.
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            reset,
  i2s_rx_capture_if.slave bus
);

  localparam int CNT_W = cnt_width(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_WIDTH);

  if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > I2S_SLOT_BITS) begin : g_bad_width
    $error("i2s_rx_capture: SAMPLE_WIDTH out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("i2s_rx_capture: SYNC_STAGES must be at least 2");
  end

  logic lr_s;
  logic sdata_s;
  logic bit_tick;

  i2s_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (reset),
    .bclk_i     (bus.i2s_bclk),
    .lr_i       (bus.i2s_lr),
    .sdata_i    (bus.i2s_sdata),
    .lr_o       (lr_s),
    .sdata_o    (sdata_s),
    .bit_tick_o (bit_tick)
  );

  i2s_state_t              state_q, state_d;
  logic                    chan_q, chan_d;
  logic                    lr_prev_q, lr_prev_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    left_done_q, left_done_d;
  logic [SAMPLE_WIDTH-1:0] left_sample_q, left_sample_d;
  logic [SAMPLE_WIDTH-1:0] right_sample_q, right_sample_d;
  logic                    valid_q, valid_d;
  logic                    frame_error_q, frame_error_d;

  logic                    lr_change;
  logic                    trunc;
  logic [SAMPLE_WIDTH-1:0] shift_base;
  logic [SAMPLE_WIDTH-1:0] shift_word;
  logic [CNT_W-1:0]        cnt_base;
  logic [CNT_W-1:0]        cnt_next;

  // The tick that reveals an lr change still carries the old slot's LSB, so it is
  // dropped there; the ARM tick is the new word's MSB and restarts count and shift.
  always_comb begin
    lr_change  = (lr_s != lr_prev_q);
    shift_base = (state_q == ST_ARM) ? '0 : shreg_q;
    cnt_base   = (state_q == ST_ARM) ? '0 : bit_cnt_q;
    shift_word = (shift_base << 1) | SAMPLE_WIDTH'(sdata_s);
    cnt_next   = cnt_base + 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    lr_prev_d      = lr_prev_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    left_hold_d    = left_hold_q;
    left_done_d    = left_done_q;
    left_sample_d  = left_sample_q;
    right_sample_d = right_sample_q;
    valid_d        = 1'b0;
    trunc          = 1'b0;

    if (bit_tick) begin
      lr_prev_d = lr_s;
      case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (lr_change) begin
            state_d = ST_ARM;
            chan_d  = lr_s;
          end
        end
        default: begin
          if (lr_change) begin
            trunc       = 1'b1;
            left_done_d = 1'b0;
            chan_d      = lr_s;
            state_d     = ST_ARM;
          end else begin
            shreg_d   = shift_word;
            bit_cnt_d = cnt_next;
            state_d   = ST_SHIFT;
            if (cnt_next == CNT_LAST) begin
              state_d = ST_WAIT;
              if (chan_q == I2S_LEFT) begin
                left_hold_d = shift_word;
                left_done_d = 1'b1;
              end else if (chan_q == I2S_RIGHT && left_done_q) begin
                left_sample_d  = left_hold_q;
                right_sample_d = shift_word;
                valid_d        = 1'b1;
                left_done_d    = 1'b0;
              end
            end
          end
        end
      endcase
    end

    if (trunc) begin
      frame_error_d = 1'b1;
    end else if (bus.clear_error) begin
      frame_error_d = 1'b0;
    end else begin
      frame_error_d = frame_error_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      chan_q         <= I2S_LEFT;
      lr_prev_q      <= 1'b0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      left_hold_q    <= '0;
      left_done_q    <= 1'b0;
      left_sample_q  <= '0;
      right_sample_q <= '0;
      valid_q        <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      lr_prev_q      <= lr_prev_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      left_hold_q    <= left_hold_d;
      left_done_q    <= left_done_d;
      left_sample_q  <= left_sample_d;
      right_sample_q <= right_sample_d;
      valid_q        <= valid_d;
      frame_error_q  <= frame_error_d;
    end
  end

`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A clear coinciding with a truncation leaves that truncation counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clear_error) begin
      err_cnt_d = trunc ? 8'd1 : 8'd0;
    end else if (trunc && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.left_sample  = left_sample_q;
  assign bus.right_sample = right_sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_error  = frame_error_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Directed bench for i2s_rx_capture: bclk period 32 clk, 32-bit slots, 24-bit samples.
module tb_i2s_rx_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2s_rx_capture_if #(.SAMPLE_WIDTH(24)) bus ();

  i2s_rx_capture #(
    .SAMPLE_WIDTH (24),
    .SYNC_STAGES  (2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [23:0] pl_q[$];
  logic [23:0] pr_q[$];
  int          pc_q[$];
  int          hold_viol = 0;
  logic        err_seen  = 1'b0;
  logic [23:0] prev_l    = '0;
  logic [23:0] prev_r    = '0;
  logic        prev_rst  = 1'b0;

  typedef struct {
    logic [23:0] in_l;
    logic [23:0] in_r;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;
  vec_t vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sample_valid === 1'b1) begin
      pl_q.push_back(bus.left_sample);
      pr_q.push_back(bus.right_sample);
      pc_q.push_back(cyc);
    end else if (rst_n && prev_rst &&
                 (bus.left_sample !== prev_l || bus.right_sample !== prev_r)) begin
      hold_viol++;
    end
    if (bus.err_count !== 8'd0) err_seen = 1'b1;
    prev_l   = bus.left_sample;
    prev_r   = bus.right_sample;
    prev_rst = rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] w, input int nper);
    for (int p = 0; p < nper; p++) begin
      @(negedge clk);
      bus.i2s_bclk  = 1'b0;
      bus.i2s_lr    = (p == nper - 1) ? ~ch : ch;
      bus.i2s_sdata = w[31-p];
      repeat (16) @(negedge clk);
      bus.i2s_bclk = 1'b1;
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, {l, 8'h00}, 32);
    send_slot(1'b1, {r, 8'h00}, 32);
  endtask

  task automatic clear_q();
    pl_q.delete();
    pr_q.delete();
    pc_q.delete();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_error = 1'b1;
    @(negedge clk);
    bus.clear_error = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " left"},  32'(bus.left_sample),  32'h0);
    check({tag, " right"}, 32'(bus.right_sample), 32'h0);
    check({tag, " valid"}, 32'(bus.sample_valid), 32'h0);
    check({tag, " ferr"},  32'(bus.frame_error),  32'h0);
    check({tag, " ecnt"},  32'(bus.err_count),    32'h0);
  endtask

  initial begin
    vecs[0] = '{24'hABCDEF, 24'h123456, 24'hABCDEF, 24'h123456};
    vecs[1] = '{24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF};
    vecs[2] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
    vecs[3] = '{24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5};

    rst_n           = 1'b0;
    bus.i2s_bclk    = 1'b0;
    bus.i2s_lr      = 1'b0;
    bus.i2s_sdata   = 1'b0;
    bus.clear_error = 1'b0;
    repeat (5) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Single frame, preceded by a full right slot that is dropped.
    clear_q();
    send_slot(1'b1, 32'h0, 32);
    send_frame(vecs[0].in_l, vecs[0].in_r);
    repeat (8) @(negedge clk);
    check("one-frame pulses", pl_q.size(), 1);
    if (pl_q.size() >= 1) begin
      check("one-frame left",  32'(pl_q[0]), 32'(vecs[0].exp_l));
      check("one-frame right", 32'(pr_q[0]), 32'(vecs[0].exp_r));
    end
    check("one-frame ferr", 32'(bus.frame_error), 32'h0);

    // Three back-to-back frames.
    clear_q();
    for (int i = 1; i < 4; i++) send_frame(vecs[i].in_l, vecs[i].in_r);
    repeat (8) @(negedge clk);
    check("b2b pulses", pl_q.size(), 3);
    for (int i = 0; i < 3 && i < pl_q.size(); i++) begin
      check($sformatf("b2b left%0d", i),  32'(pl_q[i]), 32'(vecs[i+1].exp_l));
      check($sformatf("b2b right%0d", i), 32'(pr_q[i]), 32'(vecs[i+1].exp_r));
      if (i > 0) check($sformatf("b2b spacing%0d", i), pc_q[i] - pc_q[i-1], 2048);
    end

    // Start-up in the middle of a right slot.
    rst_n      = 1'b0;
    bus.i2s_lr = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    send_slot(1'b1, 32'h99999900 << 20, 12);
    check("midstart early pulses", pl_q.size(), 0);
    send_frame(24'hC0FFEE, 24'h0BEEF0);
    repeat (8) @(negedge clk);
    check("midstart pulses", pl_q.size(), 1);
    if (pl_q.size() >= 1) begin
      check("midstart left",  32'(pl_q[0]), 32'hC0FFEE);
      check("midstart right", 32'(pr_q[0]), 32'h0BEEF0);
    end
    pulse_clear();
    check("clear ferr", 32'(bus.frame_error), 32'h0);

    // Left slot cut after 16 bits, then a good frame.
    clear_q();
    send_slot(1'b0, 32'hDEADBE00, 17);
    send_slot(1'b1, 32'h77777700, 32);
    check("trunc ferr", 32'(bus.frame_error), 32'h1);
    check("trunc pulses", pl_q.size(), 0);
    send_frame(24'h13579B, 24'h2468AC);
    repeat (8) @(negedge clk);
    check("after-trunc pulses", pl_q.size(), 1);
    if (pl_q.size() >= 1) begin
      check("after-trunc left",  32'(pl_q[0]), 32'h13579B);
      check("after-trunc right", 32'(pr_q[0]), 32'h2468AC);
    end
    check("after-trunc ferr held", 32'(bus.frame_error), 32'h1);
    pulse_clear();
    check("trunc clear ferr", 32'(bus.frame_error), 32'h0);

    // Reset pulse in the middle of a right word.
    clear_q();
    send_slot(1'b0, {24'h444444, 8'h00}, 32);
    fork
      send_slot(1'b1, {24'h333333, 8'h00}, 32);
      begin
        repeat (10 * 32 + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check("midreset pulses", pl_q.size(), 0);
    send_frame(24'h0A0B0C, 24'hF0E0D0);
    repeat (8) @(negedge clk);
    check("post-reset pulses", pl_q.size(), 1);
    if (pl_q.size() >= 1) begin
      check("post-reset left",  32'(pl_q[0]), 32'h0A0B0C);
      check("post-reset right", 32'(pr_q[0]), 32'hF0E0D0);
    end
    pulse_clear();

    // Repeated truncations: two per short frame.
    clear_q();
`ifdef I2S_RX_ERR_CNT_EN
    check("ecnt after clear", 32'(bus.err_count), 32'h0);
    for (int i = 0; i < 150; i++) begin
      send_slot(1'b0, 32'hFFFFFFFF, 3);
      send_slot(1'b1, 32'hFFFFFFFF, 3);
    end
    repeat (8) @(negedge clk);
    check("ecnt saturated", 32'(bus.err_count), 32'd255);
`else
    for (int i = 0; i < 4; i++) begin
      send_slot(1'b0, 32'hFFFFFFFF, 3);
      send_slot(1'b1, 32'hFFFFFFFF, 3);
    end
    repeat (8) @(negedge clk);
    check("ecnt tied off", 32'(bus.err_count), 32'h0);
    check("ecnt never nonzero", 32'(err_seen), 32'h0);
`endif
    check("many-trunc ferr", 32'(bus.frame_error), 32'h1);
    check("many-trunc pulses", pl_q.size(), 0);
    check("output hold violations", hold_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
